// File: rtl/cp0_exc_seq_pkg.sv
// Shared definitions for the CP0 exception sequencer: register numbers,
// Status/Cause field positions, ExcCode values and sequencer states.
package cp0_exc_seq_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int unsigned ST_IE    = 0;
    localparam int unsigned ST_EXL   = 1;
    localparam int unsigned ST_IM_LO = 8;
    localparam int unsigned ST_BEV   = 22;

    localparam int unsigned CA_EXC_LO = 2;
    localparam int unsigned CA_IP_LO  = 8;
    localparam int unsigned CA_IV     = 23;
    localparam int unsigned CA_BD     = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_STAT,
        S_RD_CAUSE,
        S_WR_EPC,
        S_WR_BADV,
        S_WR_CAUSE,
        S_WR_STAT,
        S_REDIR,
        S_RD_EPC
    } state_e;

endpackage

// File: rtl/cp0_int_detect.sv
// Interrupt-pending detect from the Status/Cause shadows and live interrupt lines.
module cp0_int_detect (
    input  logic       ie_i,
    input  logic       exl_i,
    input  logic [7:0] im_i,
    input  logic [1:0] ip_sw_i,
    input  logic [5:0] hw_int_i,
    input  logic       timer_int_i,
    output logic       int_pend_o
);

    logic [7:0] ip_all;

    // The timer shares the top hardware line, as on MIPS32 without EIC.
    assign ip_all     = {hw_int_i[5] | timer_int_i, hw_int_i[4:0], ip_sw_i};
    assign int_pend_o = ie_i & ~exl_i & (|(ip_all & im_i));

endmodule

// File: rtl/cp0_exc_seq.sv
// CP0 access sequencer: owns the CP0 read/write ports, runs exception,
// interrupt and ERET read-modify-write sequences. Optional macro: CP0_IV_VECTOR_EN.
module cp0_exc_seq
    import cp0_exc_seq_pkg::*;
#(
    parameter logic [31:0] VEC_BEV  = 32'hBFC00380,
    parameter logic [31:0] VEC_NORM = 32'h80000180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic [4:0]  pipe_raddr,
    output logic [31:0] pipe_rdata,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        exc_has_bad,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_req,
    input  logic [5:0]  hw_int,
    input  logic        timer_int,
    output logic        cp0_wen,
    output logic [4:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic [4:0]  cp0_raddr,
    input  logic [31:0] cp0_rdata,
    output logic        stall,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, badv_q, badv_d;
    logic [31:0] stat_q, stat_d, cause_q, cause_d, epc_q, epc_d;
    logic        bd_q, bd_d, has_bad_q, has_bad_d, eret_q, eret_d;
    logic [4:0]  code_q, code_d;

    logic        seq_wen_q, seq_wen_d;
    logic [4:0]  seq_waddr_q, seq_waddr_d, seq_raddr_q, seq_raddr_d;
    logic [31:0] seq_wdata_q, seq_wdata_d;
    logic        redir_q, redir_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        sh_bev_q, sh_bev_d, sh_exl_q, sh_exl_d, sh_ie_q, sh_ie_d;
    logic [7:0]  sh_im_q, sh_im_d;
    logic [1:0]  sh_ip_q, sh_ip_d;
`ifdef CP0_IV_VECTOR_EN
    logic        sh_iv_q, sh_iv_d;
`endif

    logic        int_pend, idle, take_exc, take_int, take_eret, accept;
    logic [31:0] vec_pc;

    cp0_int_detect u_int_detect (
        .ie_i        (sh_ie_q),
        .exl_i       (sh_exl_q),
        .im_i        (sh_im_q),
        .ip_sw_i     (sh_ip_q),
        .hw_int_i    (hw_int),
        .timer_int_i (timer_int),
        .int_pend_o  (int_pend)
    );

    assign idle      = (state_q == S_IDLE);
    assign take_exc  = exc_req;
    assign take_int  = ~exc_req & int_pend & mem_valid;
    assign take_eret = ~exc_req & ~take_int & eret_req;
    assign accept    = idle & (take_exc | take_int | take_eret);

    assign cp0_wen        = idle ? (pipe_wen & ~accept) : seq_wen_q;
    assign cp0_waddr      = idle ? pipe_waddr : seq_waddr_q;
    assign cp0_wdata      = idle ? pipe_wdata : seq_wdata_q;
    assign cp0_raddr      = idle ? pipe_raddr : seq_raddr_q;
    assign pipe_rdata     = cp0_rdata;
    assign stall          = ~idle | accept;
    assign flush          = redir_q;
    assign redirect_valid = redir_q;
    assign redirect_pc    = redir_pc_q;

    always_comb begin
        vec_pc = sh_bev_q ? VEC_BEV : VEC_NORM;
`ifdef CP0_IV_VECTOR_EN
        if (code_q == EXC_INT && sh_iv_q) vec_pc = vec_pc + 32'h0000_0080;
`endif
    end

    // Outputs for a state are computed from state_d so they are registered
    // on entry; WR_* data uses stat_d/cause_d to catch a same-cycle read.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        bd_d      = bd_q;
        code_d    = code_q;
        badv_d    = badv_q;
        has_bad_d = has_bad_q;
        eret_d    = eret_q;
        stat_d    = stat_q;
        cause_d   = cause_q;
        epc_d     = epc_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pc_d      = mem_pc;
                    bd_d      = mem_bd;
                    code_d    = take_exc ? exc_code : EXC_INT;
                    badv_d    = exc_badvaddr;
                    has_bad_d = take_exc & exc_has_bad;
                    eret_d    = take_eret;
                    state_d   = take_eret ? S_RD_EPC : S_RD_STAT;
                end
            end
            S_RD_EPC: begin
                epc_d   = cp0_rdata;
                state_d = S_RD_STAT;
            end
            S_RD_STAT: begin
                stat_d  = cp0_rdata;
                state_d = eret_q ? S_WR_STAT : S_RD_CAUSE;
            end
            S_RD_CAUSE: begin
                cause_d = cp0_rdata;
                if (!stat_q[ST_EXL]) state_d = S_WR_EPC;
                else                 state_d = has_bad_q ? S_WR_BADV : S_WR_CAUSE;
            end
            S_WR_EPC:   state_d = has_bad_q ? S_WR_BADV : S_WR_CAUSE;
            S_WR_BADV:  state_d = S_WR_CAUSE;
            S_WR_CAUSE: state_d = S_WR_STAT;
            S_WR_STAT:  state_d = S_REDIR;
            default:    state_d = S_IDLE;
        endcase

        seq_wen_d   = 1'b0;
        seq_waddr_d = '0;
        seq_wdata_d = '0;
        seq_raddr_d = '0;
        redir_d     = 1'b0;
        redir_pc_d  = '0;

        case (state_d)
            S_RD_EPC:   seq_raddr_d = CP0_EPC;
            S_RD_STAT:  seq_raddr_d = CP0_STATUS;
            S_RD_CAUSE: seq_raddr_d = CP0_CAUSE;
            S_WR_EPC: begin
                seq_wen_d   = 1'b1;
                seq_waddr_d = CP0_EPC;
                seq_wdata_d = pc_q;
            end
            S_WR_BADV: begin
                seq_wen_d   = 1'b1;
                seq_waddr_d = CP0_BADVADDR;
                seq_wdata_d = badv_q;
            end
            S_WR_CAUSE: begin
                seq_wen_d   = 1'b1;
                seq_waddr_d = CP0_CAUSE;
                seq_wdata_d = cause_d;
                seq_wdata_d[CA_EXC_LO +: 5] = code_q;
                if (!stat_q[ST_EXL]) seq_wdata_d[CA_BD] = bd_q;
            end
            S_WR_STAT: begin
                seq_wen_d   = 1'b1;
                seq_waddr_d = CP0_STATUS;
                seq_wdata_d = stat_d;
                seq_wdata_d[ST_EXL] = ~eret_q;
            end
            S_REDIR: begin
                redir_d    = 1'b1;
                redir_pc_d = eret_q ? epc_q : vec_pc;
            end
            default: ;
        endcase
    end

    always_comb begin
        sh_bev_d = sh_bev_q;
        sh_im_d  = sh_im_q;
        sh_exl_d = sh_exl_q;
        sh_ie_d  = sh_ie_q;
        sh_ip_d  = sh_ip_q;
`ifdef CP0_IV_VECTOR_EN
        sh_iv_d  = sh_iv_q;
`endif
        if (state_q == S_RD_STAT) begin
            sh_bev_d = cp0_rdata[ST_BEV];
            sh_im_d  = cp0_rdata[ST_IM_LO +: 8];
            sh_exl_d = cp0_rdata[ST_EXL];
            sh_ie_d  = cp0_rdata[ST_IE];
        end
        if (state_q == S_RD_CAUSE) begin
            sh_ip_d = cp0_rdata[CA_IP_LO +: 2];
`ifdef CP0_IV_VECTOR_EN
            sh_iv_d = cp0_rdata[CA_IV];
`endif
        end
        if (cp0_wen && cp0_waddr == CP0_STATUS) begin
            sh_bev_d = cp0_wdata[ST_BEV];
            sh_im_d  = cp0_wdata[ST_IM_LO +: 8];
            sh_exl_d = cp0_wdata[ST_EXL];
            sh_ie_d  = cp0_wdata[ST_IE];
        end
        if (cp0_wen && cp0_waddr == CP0_CAUSE) begin
            sh_ip_d = cp0_wdata[CA_IP_LO +: 2];
`ifdef CP0_IV_VECTOR_EN
            sh_iv_d = cp0_wdata[CA_IV];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            bd_q        <= 1'b0;
            code_q      <= '0;
            badv_q      <= '0;
            has_bad_q   <= 1'b0;
            eret_q      <= 1'b0;
            stat_q      <= '0;
            cause_q     <= '0;
            epc_q       <= '0;
            seq_wen_q   <= 1'b0;
            seq_waddr_q <= '0;
            seq_wdata_q <= '0;
            seq_raddr_q <= '0;
            redir_q     <= 1'b0;
            redir_pc_q  <= '0;
            sh_bev_q    <= 1'b1;
            sh_im_q     <= '0;
            sh_exl_q    <= 1'b0;
            sh_ie_q     <= 1'b0;
            sh_ip_q     <= '0;
`ifdef CP0_IV_VECTOR_EN
            sh_iv_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            bd_q        <= bd_d;
            code_q      <= code_d;
            badv_q      <= badv_d;
            has_bad_q   <= has_bad_d;
            eret_q      <= eret_d;
            stat_q      <= stat_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            seq_wen_q   <= seq_wen_d;
            seq_waddr_q <= seq_waddr_d;
            seq_wdata_q <= seq_wdata_d;
            seq_raddr_q <= seq_raddr_d;
            redir_q     <= redir_d;
            redir_pc_q  <= redir_pc_d;
            sh_bev_q    <= sh_bev_d;
            sh_im_q     <= sh_im_d;
            sh_exl_q    <= sh_exl_d;
            sh_ie_q     <= sh_ie_d;
            sh_ip_q     <= sh_ip_d;
`ifdef CP0_IV_VECTOR_EN
            sh_iv_q     <= sh_iv_d;
`endif
        end
    end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// Directed bench for cp0_exc_seq with a behavioural CP0 register file on its ports.
module tb_cp0_exc_seq;

    logic        clk, rst;
    logic        pipe_wen;
    logic [4:0]  pipe_waddr, pipe_raddr;
    logic [31:0] pipe_wdata, pipe_rdata;
    logic        mem_valid, mem_bd;
    logic [31:0] mem_pc;
    logic        exc_req, exc_has_bad, eret_req, timer_int;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic [5:0]  hw_int;
    logic        cp0_wen;
    logic [4:0]  cp0_waddr, cp0_raddr;
    logic [31:0] cp0_wdata, cp0_rdata;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;

    cp0_exc_seq #(
        .VEC_BEV  (32'hBFC00380),
        .VEC_NORM (32'h80000180)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_wen       (pipe_wen),
        .pipe_waddr     (pipe_waddr),
        .pipe_wdata     (pipe_wdata),
        .pipe_raddr     (pipe_raddr),
        .pipe_rdata     (pipe_rdata),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_bd         (mem_bd),
        .exc_req        (exc_req),
        .exc_code       (exc_code),
        .exc_has_bad    (exc_has_bad),
        .exc_badvaddr   (exc_badvaddr),
        .eret_req       (eret_req),
        .hw_int         (hw_int),
        .timer_int      (timer_int),
        .cp0_wen        (cp0_wen),
        .cp0_waddr      (cp0_waddr),
        .cp0_wdata      (cp0_wdata),
        .cp0_raddr      (cp0_raddr),
        .cp0_rdata      (cp0_rdata),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CP0 register file: combinational read, write on clock.
    logic [31:0] regs [32];
    assign cp0_rdata = regs[cp0_raddr];
    always @(posedge clk) if (cp0_wen === 1'b1) regs[cp0_waddr] <= cp0_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [4:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          redir_cnt = 0, flush_cnt = 0, stall_cnt = 0, redir_cyc = 0;
    logic [31:0] redir_pc_s = '0;

    always @(negedge clk) begin
        if (cp0_wen === 1'b1) begin
            wa_q.push_back(cp0_waddr);
            wd_q.push_back(cp0_wdata);
        end
        if (redirect_valid === 1'b1) begin
            redir_cnt  <= redir_cnt + 1;
            redir_cyc  <= cyc;
            redir_pc_s <= redirect_pc;
        end
        if (flush === 1'b1) flush_cnt <= flush_cnt + 1;
        if (stall === 1'b1) stall_cnt <= stall_cnt + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [4:0]  ea_q[$];
    logic [31:0] ed_q[$];

    task automatic expect_w(input logic [4:0] a, input logic [31:0] d);
        ea_q.push_back(a);
        ed_q.push_back(d);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        pipe_wen   = 1'b1;
        pipe_waddr = a;
        pipe_wdata = d;
        @(posedge clk); #1;
        pipe_wen   = 1'b0;
    endtask

    task automatic clear_reqs();
        exc_req     = 1'b0;
        eret_req    = 1'b0;
        exc_has_bad = 1'b0;
        timer_int   = 1'b0;
        pipe_wen    = 1'b0;
        mem_bd      = 1'b0;
    endtask

    // Caller drives the request at posedge+1; this checks the whole sequence.
    task automatic fire_and_wait(input string tag, input int exp_lat, input logic [31:0] exp_pc);
        int a_cyc, base_r, base_f, base_s, base_w;
        base_w = wa_q.size();
        #1;
        chk({tag, "_stall_accept"}, 32'(stall), 32'd1);
        a_cyc  = cyc;
        base_r = redir_cnt;
        base_f = flush_cnt;
        base_s = stall_cnt;
        @(posedge clk); #1;
        clear_reqs();
        for (int n = 0; n < 40; n++) begin
            if (redir_cnt != base_r) break;
            @(posedge clk); #1;
        end
        chk({tag, "_redir_count"}, 32'(redir_cnt - base_r), 32'd1);
        chk({tag, "_latency"}, 32'(redir_cyc - a_cyc), 32'(exp_lat));
        chk({tag, "_redir_pc"}, redir_pc_s, exp_pc);
        chk({tag, "_flush_count"}, 32'(flush_cnt - base_f), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stall_cnt - base_s), 32'(exp_lat + 1));
        chk({tag, "_stall_after"}, 32'(stall), 32'd0);
        chk({tag, "_redir_after"}, 32'(redirect_valid), 32'd0);
        chk({tag, "_nwrites"}, 32'(wa_q.size() - base_w), 32'(ea_q.size()));
        for (int i = 0; i < ea_q.size(); i++) begin
            if (base_w + i < wa_q.size()) begin
                chk($sformatf("%s_w%0d_addr", tag, i), 32'(wa_q[base_w + i]), 32'(ea_q[i]));
                chk($sformatf("%s_w%0d_data", tag, i), wd_q[base_w + i], ed_q[i]);
            end
        end
        ea_q.delete();
        ed_q.delete();
    endtask

    logic [31:0] int_vec;
    int          base_w7, base_r7;

    initial begin
        rst = 1'b1;
        pipe_waddr = '0; pipe_wdata = '0; pipe_raddr = 5'd7;
        mem_valid = 1'b1; mem_pc = '0; exc_code = '0; exc_badvaddr = '0;
        hw_int = '0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redir_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redir_pc", redirect_pc, 32'd0);
        chk("rst_cp0_wen", 32'(cp0_wen), 32'd0);
        chk("rst_raddr", 32'(cp0_raddr), 32'd7);
        rst = 1'b0;
        @(posedge clk); #1;

        mtc0(5'd13, 32'h0);
        mtc0(5'd12, 32'h0);
        mtc0(5'd14, 32'h0);
        mtc0(5'd8,  32'h0);

        // Overflow, EXL=0, no BadVAddr: 6-cycle sequence.
        exc_req = 1'b1; exc_code = 5'd12; mem_pc = 32'h80001000; mem_bd = 1'b0;
        expect_w(5'd14, 32'h80001000);
        expect_w(5'd13, 32'h00000030);
        expect_w(5'd12, 32'h00000002);
        fire_and_wait("ov", 6, 32'h80000180);

        // AdEL with BadVAddr in a delay slot: full 7-cycle sequence.
        mtc0(5'd12, 32'h0);
        exc_req = 1'b1; exc_code = 5'd4; mem_pc = 32'h80002004; mem_bd = 1'b1;
        exc_has_bad = 1'b1; exc_badvaddr = 32'h00001003;
        expect_w(5'd14, 32'h80002004);
        expect_w(5'd8,  32'h00001003);
        expect_w(5'd13, 32'h80000010);
        expect_w(5'd12, 32'h00000002);
        fire_and_wait("adel", 7, 32'h80000180);

        // EXL already set, BEV=1: no EPC write, BD kept at 1.
        mtc0(5'd12, 32'h00400002);
        exc_req = 1'b1; exc_code = 5'd10; mem_pc = 32'h80003000; mem_bd = 1'b0;
        expect_w(5'd13, 32'h80000028);
        expect_w(5'd12, 32'h00400002);
        fire_and_wait("exl", 5, 32'hBFC00380);

        // Timer interrupt with IV=1; the concurrent pipe write must be dropped.
        mtc0(5'd12, 32'h0000FF01);
        mtc0(5'd13, 32'h00800000);
        timer_int = 1'b1; mem_pc = 32'h80004000; mem_bd = 1'b0;
        pipe_wen = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h12345678;
`ifdef CP0_IV_VECTOR_EN
        int_vec = 32'h80000200;
`else
        int_vec = 32'h80000180;
`endif
        expect_w(5'd14, 32'h80004000);
        expect_w(5'd13, 32'h00800000);
        expect_w(5'd12, 32'h0000FF03);
        fire_and_wait("int", 6, int_vec);

        // ERET: clear EXL and return to EPC.
        mtc0(5'd14, 32'h80001234);
        eret_req = 1'b1;
        expect_w(5'd12, 32'h0000FF01);
        fire_and_wait("eret", 4, 32'h80001234);

        // Exception and ERET together: exception wins.
        exc_req = 1'b1; eret_req = 1'b1; exc_code = 5'd8; mem_pc = 32'h80005000; mem_bd = 1'b0;
        expect_w(5'd14, 32'h80005000);
        expect_w(5'd13, 32'h00800020);
        expect_w(5'd12, 32'h0000FF03);
        fire_and_wait("exc_eret", 6, 32'h80000180);

        // Reset while in WR_CAUSE: only the EPC write may have happened.
        mtc0(5'd12, 32'h0);
        base_w7 = wa_q.size();
        base_r7 = redir_cnt;
        exc_req = 1'b1; exc_code = 5'd12; mem_pc = 32'h80006000; mem_bd = 1'b0;
        @(posedge clk); #1;
        clear_reqs();
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_in_wrcause", 32'(cp0_waddr), 32'd13);
        rst = 1'b1;
        pipe_raddr = 5'd14;
        #1;
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_wen", 32'(cp0_wen), 32'd0);
        chk("rst_mid_raddr", 32'(cp0_raddr), 32'd14);
        chk("rst_mid_rdata", pipe_rdata, 32'h80006000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_nwrites", 32'(wa_q.size() - base_w7), 32'd1);
        if (wa_q.size() > base_w7)
            chk("rst_mid_w0_addr", 32'(wa_q[base_w7]), 32'd14);
        chk("rst_mid_no_redir", 32'(redir_cnt - base_r7), 32'd0);
        chk("rst_mid_stall_after", 32'(stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=%0d exp=0", 1);
        $fatal(1, "timeout");
    end

endmodule
